// File: rtl/rsa_pkg.sv
// rsa_pkg: shared constants and FSM state type for the RSA modular-exponentiation engine.
// Contents: bus width, CTRL address, STATUS/CTRL bit positions, fsm_state_t.
package rsa_pkg;
    localparam int BUS_W      = 32;
    localparam int CTRL_ADDR  = 0;
    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_ERROR   = 2;
    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;
    typedef enum logic [2:0] {IDLE, CHECK, SQR, MUL, FIN} fsm_state_t;
endpackage

// File: rtl/rsa_modmul.sv
// rsa_modmul: iterative Blakley modular multiplier, p = a*b mod n, one bit of a per cycle.
// Ports: clk, reset (sync, active-high); start loads a, b, n (all WIDTH bits, a,b < n);
//        p is the product; done pulses once, the cycle after the last of WIDTH iterations.
module rsa_modmul #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] p,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_r, b_r, n_r;
    logic [WIDTH+1:0] acc, s0, s1, s2, nx;
    logic [CW-1:0]    cnt;
    logic             run;

    // acc < n holds throughout, so 2*acc + b < 3n and two subtractions always suffice.
    always_comb begin
        nx = {2'b00, n_r};
        s0 = {acc[WIDTH:0], 1'b0} + (a_r[WIDTH-1] ? {2'b00, b_r} : '0);
        s1 = (s0 >= nx) ? s0 - nx : s0;
        s2 = (s1 >= nx) ? s1 - nx : s1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run  <= 1'b0;
            done <= 1'b0;
            acc  <= '0;
            cnt  <= '0;
            a_r  <= '0;
            b_r  <= '0;
            n_r  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                run <= 1'b1;
                a_r <= a;
                b_r <= b;
                n_r <= n;
                acc <= '0;
                cnt <= CW'(WIDTH);
            end else if (run) begin
                acc <= s2;
                a_r <= a_r << 1;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign p = acc[WIDTH-1:0];
endmodule

// File: rtl/rsa_modexp_engine.sv
// rsa_modexp_engine: memory-mapped RSA engine computing RESULT = BASE^EXP mod MOD (left-to-right
// square-and-multiply over rsa_modmul).
// Ports: clk, reset (sync, active-high); chipselect/write/address/writedata slave bus;
//        readdata registered read data (valid the cycle after a read); irq = STATUS.done.
// Map (W = WIDTH/32): 0 CTRL/STATUS, 1..W BASE, W+1..2W EXP, 2W+1..3W MOD, 3W+1..4W RESULT,
//        4W+1 CYCLES. Define RSA_CYCLE_CNT_EN to include the busy-cycle counter; otherwise
//        CYCLES reads 0.
module rsa_modexp_engine
    import rsa_pkg::*;
#(
    parameter int WIDTH  = 128,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [BUS_W-1:0]  writedata,
    output logic [BUS_W-1:0]  readdata,
    output logic              irq
);
    localparam int W  = WIDTH / BUS_W;
    localparam int IW = $clog2(WIDTH);

    fsm_state_t       state, state_n;
    logic [WIDTH-1:0] base_r, exp_r, mod_r, result_r, acc, mm_b, mm_p;
    logic [IW-1:0]    idx;
    logic             done_r, error_r, launched, mm_start, mm_done;
    logic             busy, wr, ctrl_wr, start_acc, bad, step_end;
    logic [BUS_W-1:0] rd_mux, status;

    assign busy      = state != IDLE;
    assign wr        = chipselect && write;
    assign ctrl_wr   = wr && address == ADDR_W'(CTRL_ADDR);
    assign start_acc = ctrl_wr && writedata[CTRL_START] && !busy;
    assign bad       = mod_r == '0 || base_r >= mod_r;
    // A bit is finished when its multiply completes, or its square completes with EXP[i]=0.
    assign step_end  = mm_done && (state == MUL || !exp_r[idx]);
    assign irq       = done_r;

    rsa_modmul #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (mm_start),
        .a     (acc),
        .b     (mm_b),
        .n     (mod_r),
        .p     (mm_p),
        .done  (mm_done)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        mm_start = 1'b0;
        mm_b     = acc;
        case (state)
            IDLE:  state_n = start_acc ? CHECK : IDLE;
            CHECK: state_n = bad ? IDLE : SQR;
            SQR: begin
                mm_start = !launched;
                if (mm_done) state_n = exp_r[idx] ? MUL : (idx == '0 ? FIN : SQR);
            end
            MUL: begin
                mm_start = !launched;
                mm_b     = base_r;
                if (mm_done) state_n = idx == '0 ? FIN : SQR;
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_r   <= '0;
            exp_r    <= '0;
            mod_r    <= '0;
            result_r <= '0;
            acc      <= '0;
            idx      <= '0;
            done_r   <= 1'b0;
            error_r  <= 1'b0;
            launched <= 1'b0;
            readdata <= '0;
        end else begin
            for (int k = 0; k < W; k++) begin
                if (wr && !busy && address == ADDR_W'(1 + k))         base_r[BUS_W*k +: BUS_W] <= writedata;
                if (wr && !busy && address == ADDR_W'(1 + W + k))     exp_r[BUS_W*k +: BUS_W]  <= writedata;
                if (wr && !busy && address == ADDR_W'(1 + 2 * W + k)) mod_r[BUS_W*k +: BUS_W]  <= writedata;
            end
            if (ctrl_wr && writedata[CTRL_CLEAR]) begin
                done_r  <= 1'b0;
                error_r <= 1'b0;
            end
            if (mm_done)       launched <= 1'b0;
            else if (mm_start) launched <= 1'b1;
            if (state == CHECK) begin
                acc <= (mod_r == WIDTH'(1)) ? '0 : WIDTH'(1);
                idx <= IW'(WIDTH - 1);
                if (bad) begin
                    error_r <= 1'b1;
                    done_r  <= 1'b1;
                end
            end
            if (mm_done) acc <= mm_p;
            if (step_end) idx <= idx - IW'(1);
            if (state == FIN) begin
                result_r <= acc;
                done_r   <= 1'b1;
            end
            if (chipselect && !write) readdata <= rd_mux;
        end
    end

`ifdef RSA_CYCLE_CNT_EN
    logic [BUS_W-1:0] cycles;

    always_ff @(posedge clk) begin
        if (reset)                         cycles <= '0;
        else if (start_acc)                cycles <= '0;
        else if (busy && cycles != '1)     cycles <= cycles + BUS_W'(1);
    end
`endif

    always_comb begin
        status           = '0;
        status[ST_BUSY]  = busy;
        status[ST_DONE]  = done_r;
        status[ST_ERROR] = error_r;
        rd_mux           = '0;
        if (address == ADDR_W'(CTRL_ADDR)) rd_mux = status;
        for (int k = 0; k < W; k++) begin
            if (address == ADDR_W'(1 + k))         rd_mux = base_r[BUS_W*k +: BUS_W];
            if (address == ADDR_W'(1 + W + k))     rd_mux = exp_r[BUS_W*k +: BUS_W];
            if (address == ADDR_W'(1 + 2 * W + k)) rd_mux = mod_r[BUS_W*k +: BUS_W];
            if (address == ADDR_W'(1 + 3 * W + k)) rd_mux = result_r[BUS_W*k +: BUS_W];
        end
`ifdef RSA_CYCLE_CNT_EN
        if (address == ADDR_W'(4 * W + 1)) rd_mux = cycles;
`endif
    end
endmodule

// File: tb/tb_rsa_modexp_engine.sv
// tb_rsa_modexp_engine: scoreboard bench for rsa_modexp_engine at WIDTH=32.
module tb_rsa_modexp_engine;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0, reset = 1'b1, cs = 1'b0, we = 1'b0, chk = 1'b0, rd_v = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [31:0]       wd = '0, rdata;
    logic              irq;
    int                errors = 0, checks = 0, n;
    logic [31:0]       rb, re, rm;

    typedef struct {
        string       nm;
        logic [31:0] v;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    rsa_modexp_engine #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (cs),
        .write      (we),
        .address    (addr),
        .writedata  (wd),
        .readdata   (rdata),
        .irq        (irq)
    );

    // Monitor: every checked read returns data the following cycle; pop and compare then.
    always @(posedge clk) rd_v <= cs && !we && chk;

    always @(negedge clk) begin
        if (rd_v) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard-empty got=%0d", rdata);
            end else begin
                mon_e = q.pop_front();
                if (rdata !== mon_e.v) begin
                    errors++;
                    $display("FAIL %s got=%0d expected=%0d", mon_e.nm, rdata, mon_e.v);
                end
            end
        end
    end

    function automatic logic [31:0] mexp(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
        longint unsigned r;
        r = 64'd1 % m;
        for (int i = 31; i >= 0; i--) begin
            r = (r * r) % m;
            if (e[i]) r = (r * b) % m;
        end
        return r[31:0];
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                       input logic c, input string nm, input logic [31:0] e);
        cs = 1'b1; we = w; addr = a; wd = d; chk = c;
        if (c) q.push_back('{nm: nm, v: e});
        @(negedge clk);
        cs = 1'b0; we = 1'b0; chk = 1'b0;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        bus(1'b1, a, d, 1'b0, "", 32'd0);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input string nm, input logic [31:0] e);
        bus(1'b0, a, 32'd0, 1'b1, nm, e);
    endtask

    // Poll STATUS every cycle; each read reflects that cycle, so the count equals busy cycles seen.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        for (int i = 0; i < 5000; i++) begin
            bus(1'b0, 5'd0, 32'd0, 1'b0, "", 32'd0);
            if (!rdata[0]) return;
            cnt++;
        end
        checks++;
        errors++;
        $display("FAIL busy-timeout got=%0d expected=idle", cnt);
    endtask

    task automatic op(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m, output int cnt);
        wr(5'd1, b);
        wr(5'd2, e);
        wr(5'd3, m);
        wr(5'd0, 32'd3);
        wait_idle(cnt);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst-readdata", rdata, 0);
        check("rst-irq", {31'd0, irq}, 0);
        rd(5'd0, "rst-status", 0);
        rd(5'd4, "rst-result", 0);
        rd(5'd1, "rst-base", 0);
        rd(5'd7, "unmapped", 0);

        op(4, 13, 497, n);
        check("t1-busy", n, 1192);
        rd(5'd0, "t1-status", 2);
        rd(5'd4, "t1-result", 445);
        check("t1-irq", {31'd0, irq}, 1);

        op(65, 17, 3233, n);
        check("t2-busy", n, 1158);
        rd(5'd4, "t2-enc", 2790);
`ifdef RSA_CYCLE_CNT_EN
        rd(5'd5, "t2-cycles", 1158);
`else
        rd(5'd5, "t2-cycles", 0);
`endif
        op(2790, 2753, 3233, n);
        check("t2-dec-busy", n, 1260);
        rd(5'd4, "t2-dec", 65);

        op(4, 0, 497, n);
        rd(5'd4, "t3-exp0", 1);
        op(4, 0, 0, n);
        check("t3-mod0-busy", n, 1);
        rd(5'd0, "t3-mod0-status", 6);
        rd(5'd4, "t3-mod0-result", 1);
        op(0, 5, 1, n);
        rd(5'd0, "t3-mod1-status", 2);
        rd(5'd4, "t3-mod1-result", 0);
        op(500, 5, 497, n);
        rd(5'd0, "t3-big-status", 6);

        wr(5'd1, 4);
        wr(5'd2, 13);
        wr(5'd3, 497);
        wr(5'd0, 3);
        wr(5'd1, 7);
        wr(5'd2, 5);
        wr(5'd3, 11);
        wr(5'd0, 1);
        wait_idle(n);
        check("t4-busy", n, 1188);
        rd(5'd4, "t4-result", 445);
        rd(5'd1, "t4-base", 4);
        rd(5'd2, "t4-exp", 13);
        rd(5'd3, "t4-mod", 497);
        wr(5'd0, 2);
        rd(5'd0, "t4-clear", 0);
        check("t4-irq", {31'd0, irq}, 0);

        wr(5'd0, 3);
        repeat (100) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5-readdata", rdata, 0);
        check("t5-irq", {31'd0, irq}, 0);
        rd(5'd0, "t5-status", 0);
        rd(5'd4, "t5-result", 0);
        rd(5'd1, "t5-base", 0);
        op(4, 13, 497, n);
        check("t5-busy", n, 1192);
        rd(5'd4, "t5-restart", 445);

        for (int i = 0; i < 3; i++) begin
            rm = $urandom() | 32'h8000_0001;
            rb = $urandom() % rm;
            re = $urandom();
            op(rb, re, rm, n);
            check("rnd-busy", n, 2 + (32 + $countones(re)) * 34);
            rd(5'd4, "rnd-result", mexp(rb, re, rm));
        end

        repeat (3) @(negedge clk);
        check("sb-drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
